// File: rtl/smith_waterman_pkg.sv
// Shared types for the Smith-Waterman read engine: host-control words,
// buffer descriptors, a compact CCI-P channel model and the engine FSM states.
package smith_waterman_pkg;

  localparam int HC_BUFFER_SIZE = 4;
  localparam int HC_ADDR_W      = 42;

  typedef logic [31:0]          t_hc_control;
  typedef logic [HC_ADDR_W-1:0] t_hc_address;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  localparam t_hc_control HC_CTL_IDLE  = 32'h0;
  localparam t_hc_control HC_CTL_START = 32'h1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    DRAIN    = 3'd2,
    WR_DSM   = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5
  } t_sw_state;

  typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRFENCE = 4'h4} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    t_hc_address  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_hc_address  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  // Status line written to the DSM on completion: completion flag plus line count.
  function automatic t_ccip_clData dsm_status_line(input logic [15:0] lines);
    t_ccip_clData d;
    d        = '0;
    d[31:0]  = 32'h1;
    d[63:32] = {16'h0, lines};
    return d;
  endfunction

endpackage

// File: rtl/smith_waterman_rd_tracker.sv
// Bookkeeping for one read stream: next line to request, responses seen so far
// and the number of reads currently in flight.
module smith_waterman_rd_tracker
  import smith_waterman_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_issue,
  input  logic          i_rsp,
  input  logic [15:0]   i_lines,
  output logic [15:0]   o_req_idx,
  output logic [OW-1:0] o_outstanding,
  output logic          o_room,
  output logic          o_issue_last,
  output logic          o_rsp_last
);

  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  logic [15:0]   r_req_idx;
  logic [15:0]   r_rsp_cnt;
  logic [OW-1:0] r_outstanding;
  logic [15:0]   w_last_idx;

  assign w_last_idx    = i_lines - 16'd1;
  assign o_req_idx     = r_req_idx;
  assign o_outstanding = r_outstanding;
  assign o_room        = r_outstanding < MAX_OUT;
  assign o_issue_last  = r_req_idx == w_last_idx;
  assign o_rsp_last    = r_rsp_cnt == w_last_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_idx     <= '0;
      r_rsp_cnt     <= '0;
      r_outstanding <= '0;
    end else if (i_clear) begin
      r_req_idx     <= '0;
      r_rsp_cnt     <= '0;
      r_outstanding <= '0;
    end else begin
      if (i_issue) r_req_idx <= r_req_idx + 16'd1;
      if (i_rsp)   r_rsp_cnt <= r_rsp_cnt + 16'd1;
      // Simultaneous issue and response cancel out.
      case ({i_issue, i_rsp})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: rtl/smith_waterman_rd_engine.sv
// Streams one host buffer over CCI-P channel 0 and reports completion by
// writing a status line to the DSM over channel 1.
module smith_waterman_rd_engine
  import smith_waterman_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int BUF_SEL         = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  t_hc_control    hc_control,
  input  t_hc_address    hc_dsm_base,
  input  t_hc_buffer     hc_buffer [HC_BUFFER_SIZE],
  input  logic           c0TxAlmFull,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c0_Rx c0Rx,
  input  t_if_ccip_c1_Rx c1Rx,
  output t_if_ccip_c0_Tx c0Tx,
  output t_if_ccip_c1_Tx c1Tx,
  output logic           rd_valid,
  output logic [511:0]   rd_data,
  output logic [15:0]    rd_idx,
  output logic           rd_last,
  output logic           busy,
  output logic           done
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  t_sw_state      r_state;
  t_sw_state      w_state_next;
  logic           r_ctl_was_start;
  t_hc_address    r_base;
  logic [15:0]    r_lines;
  t_if_ccip_c0_Tx r_c0tx;
  t_if_ccip_c1_Tx r_c1tx;
  logic           r_rd_valid;
  logic           r_rd_last;
  logic [511:0]   r_rd_data;
  logic [15:0]    r_rd_idx;

  logic           w_is_start;
  logic           w_start_edge;
  logic           w_clear;
  logic           w_issue;
  logic           w_rsp;
  logic           w_wr_dsm;
  logic           w_ack;
  t_hc_address    w_buf_addr;
  logic [15:0]    w_buf_lines;
  logic [15:0]    w_req_idx;
  logic [OW-1:0]  w_outstanding;
  logic           w_room;
  logic           w_issue_last;
  logic           w_rsp_last;
  logic           w_unused_ok;

  // The edge detector comes out of reset as if start were already seen, so a
  // start level held across reset cannot launch a transfer.
  assign w_is_start   = hc_control == HC_CTL_START;
  assign w_start_edge = w_is_start && !r_ctl_was_start;
  assign w_buf_addr   = hc_buffer[BUF_SEL].address;
  assign w_buf_lines  = hc_buffer[BUF_SEL].size[15:0];
  assign w_clear      = (r_state == IDLE) && w_start_edge;
  assign w_issue      = (r_state == REQ) && !c0TxAlmFull && w_room;
  assign w_rsp        = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE) &&
                        (r_state != IDLE) && (r_state != DONE);
  assign w_wr_dsm     = (r_state == WR_DSM) && !c1TxAlmFull;
  assign w_ack        = (r_state == WAIT_ACK) && c1Rx.rspValid &&
                        (c1Rx.hdr.resp_type == eRSP_WRLINE);

  smith_waterman_rd_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .OW             (OW)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_issue      (w_issue),
    .i_rsp        (w_rsp),
    .i_lines      (r_lines),
    .o_req_idx    (w_req_idx),
    .o_outstanding(w_outstanding),
    .o_room       (w_room),
    .o_issue_last (w_issue_last),
    .o_rsp_last   (w_rsp_last)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_start_edge) w_state_next = (w_buf_lines == 16'd0) ? WR_DSM : REQ;
      REQ:      if (w_issue && w_issue_last) w_state_next = DRAIN;
      DRAIN:    if (w_rsp && w_rsp_last) w_state_next = WR_DSM;
      WR_DSM:   if (w_wr_dsm) w_state_next = WAIT_ACK;
      WAIT_ACK: if (w_ack) w_state_next = DONE;
      DONE:     if (hc_control == HC_CTL_IDLE) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_ctl_was_start <= 1'b1;
      r_base          <= '0;
      r_lines         <= '0;
      r_c0tx          <= '0;
      r_c1tx          <= '0;
      r_rd_valid      <= 1'b0;
      r_rd_last       <= 1'b0;
      r_rd_data       <= '0;
      r_rd_idx        <= '0;
    end else begin
      r_state         <= w_state_next;
      r_ctl_was_start <= w_is_start;
      if (w_clear) begin
        r_base  <= w_buf_addr;
        r_lines <= w_buf_lines;
      end
      r_c0tx.valid <= w_issue;
      if (w_issue) begin
        r_c0tx.hdr.vc_sel   <= eVC_VA;
        r_c0tx.hdr.cl_len   <= eCL_LEN_1;
        r_c0tx.hdr.req_type <= eREQ_RDLINE_I;
        r_c0tx.hdr.address  <= r_base + t_hc_address'(w_req_idx);
        r_c0tx.hdr.mdata    <= w_req_idx;
      end
      r_c1tx.valid <= w_wr_dsm;
      if (w_wr_dsm) begin
        r_c1tx.hdr.vc_sel   <= eVC_VA;
        r_c1tx.hdr.sop      <= 1'b1;
        r_c1tx.hdr.cl_len   <= eCL_LEN_1;
        r_c1tx.hdr.req_type <= eREQ_WRLINE_I;
        r_c1tx.hdr.address  <= hc_dsm_base;
        r_c1tx.hdr.mdata    <= '0;
        r_c1tx.data         <= dsm_status_line(r_lines);
      end
      r_rd_valid <= w_rsp;
      r_rd_last  <= w_rsp && w_rsp_last;
      if (w_rsp) begin
        r_rd_data <= c0Rx.data;
        r_rd_idx  <= c0Rx.hdr.mdata;
      end
    end
  end

  // Fields of the response channels and unselected buffers that carry nothing for this engine.
  always_comb begin
    w_unused_ok = c0Rx.mmioRdValid ^ c0Rx.mmioWrValid ^ (^c0Rx.hdr.vc_used) ^
                  (^c0Rx.hdr.cl_num) ^ (^c1Rx.hdr.vc_used) ^ (^c1Rx.hdr.mdata) ^
                  (^w_outstanding);
    for (int i = 0; i < HC_BUFFER_SIZE; i++) w_unused_ok = w_unused_ok ^ (^hc_buffer[i]);
  end

  assign c0Tx     = r_c0tx;
  assign c1Tx     = r_c1tx;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_idx   = r_rd_idx;
  assign rd_last  = r_rd_last;
  assign busy     = (r_state != IDLE) && (r_state != DONE);
  assign done     = r_state == DONE;

endmodule

// File: tb/tb_smith_waterman_rd_engine.sv
// Bench for smith_waterman_rd_engine: a host/memory model answers reads with
// random data and every streamed line is checked against what memory returned.
module tb_smith_waterman_rd_engine;
  import smith_waterman_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  t_hc_address    hc_dsm_base;
  t_hc_buffer     hc_buffer [HC_BUFFER_SIZE];
  t_hc_control    hc_control [2];
  logic           c0TxAlmFull [2];
  logic           c1TxAlmFull [2];
  t_if_ccip_c0_Rx c0Rx [2];
  t_if_ccip_c1_Rx c1Rx [2];
  t_if_ccip_c0_Tx c0Tx [2];
  t_if_ccip_c1_Tx c1Tx [2];
  logic           rd_valid [2];
  logic [511:0]   rd_data [2];
  logic [15:0]    rd_idx [2];
  logic           rd_last [2];
  logic           busy [2];
  logic           done [2];

  smith_waterman_rd_engine u_dut (
    .clk(clk), .reset(reset), .hc_control(hc_control[0]), .hc_dsm_base(hc_dsm_base),
    .hc_buffer(hc_buffer), .c0TxAlmFull(c0TxAlmFull[0]), .c1TxAlmFull(c1TxAlmFull[0]),
    .c0Rx(c0Rx[0]), .c1Rx(c1Rx[0]), .c0Tx(c0Tx[0]), .c1Tx(c1Tx[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_idx(rd_idx[0]), .rd_last(rd_last[0]),
    .busy(busy[0]), .done(done[0]));

  smith_waterman_rd_engine #(.MAX_OUTSTANDING(2), .BUF_SEL(1)) u_dut2 (
    .clk(clk), .reset(reset), .hc_control(hc_control[1]), .hc_dsm_base(hc_dsm_base),
    .hc_buffer(hc_buffer), .c0TxAlmFull(c0TxAlmFull[1]), .c1TxAlmFull(c1TxAlmFull[1]),
    .c0Rx(c0Rx[1]), .c1Rx(c1Rx[1]), .c0Tx(c0Tx[1]), .c1Tx(c1Tx[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_idx(rd_idx[1]), .rd_last(rd_last[1]),
    .busy(busy[1]), .done(done[1]));

  typedef struct { int cyc; t_hc_address addr; logic [15:0] mdata; logic [7:0] attr; } req_t;
  typedef struct { int cyc; logic [15:0] idx; logic [511:0] data; logic last; } rd_t;
  typedef struct { int due; logic [15:0] mdata; } pend_t;

  req_t  reqs[$];
  rd_t   sent[$];
  rd_t   got[$];
  pend_t pend[$];
  pend_t hold[$];

  int total = 0;
  int bad   = 0;
  int cyc = 0, cur_lines, rsp_mode, rsp_lat, inflight, max_inflight, alm_viol;
  int alm_from, alm_to, wr_cnt, ack_cyc, ack_due, done_cyc;
  logic         prev_alm;
  logic [511:0] wr_data;
  t_hc_address  wr_addr;
  logic         wr_sop;
  logic [3:0]   wr_type;

  task automatic clear_logs(input int lines, input int mode, input int lat);
    reqs.delete(); sent.delete(); got.delete(); pend.delete(); hold.delete();
    cur_lines = lines; rsp_mode = mode; rsp_lat = lat;
    inflight = 0; max_inflight = 0; alm_viol = 0; alm_from = -1; alm_to = -1;
    wr_cnt = 0; ack_cyc = -1; ack_due = -1; done_cyc = -1; prev_alm = 1'b0;
    wr_data = '0; wr_addr = '0; wr_sop = 1'b0; wr_type = '0;
  endtask

  // One clock of the host/memory model: observe outputs, then drive inputs.
  // rsp_mode 0: answer each read after rsp_lat cycles; 1: hold until cur_lines
  // reads were seen, then answer newest first.
  task automatic step(input int d);
    req_t         r;
    rd_t          s;
    pend_t        p;
    logic [511:0] dat;
    logic         alm;
    @(posedge clk); #1; cyc++;
    if (c0Tx[d].valid) begin
      r.cyc = cyc; r.addr = c0Tx[d].hdr.address; r.mdata = c0Tx[d].hdr.mdata;
      r.attr = {c0Tx[d].hdr.vc_sel, c0Tx[d].hdr.cl_len, c0Tx[d].hdr.req_type};
      reqs.push_back(r);
      if (prev_alm) alm_viol++;
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
      p.due = cyc + rsp_lat; p.mdata = r.mdata;
      if (rsp_mode == 0) pend.push_back(p); else hold.push_back(p);
    end
    if (rsp_mode == 1 && hold.size() == cur_lines) begin
      while (hold.size() > 0) begin p = hold.pop_back(); p.due = cyc; pend.push_back(p); end
    end
    if (rd_valid[d]) begin
      s.cyc = cyc; s.idx = rd_idx[d]; s.data = rd_data[d]; s.last = rd_last[d];
      got.push_back(s);
    end
    if (c1Tx[d].valid) begin
      wr_cnt++; wr_data = c1Tx[d].data; wr_addr = c1Tx[d].hdr.address;
      wr_sop = c1Tx[d].hdr.sop; wr_type = c1Tx[d].hdr.req_type;
      ack_due = cyc + 2;
    end
    if (done[d] && done_cyc < 0) done_cyc = cyc;
    c0Rx[d] = '0;
    c1Rx[d] = '0;
    c0Rx[d].mmioWrValid = 1'($urandom_range(0, 1));
    c0Rx[d].mmioRdValid = 1'($urandom_range(0, 1));
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      for (int w = 0; w < 16; w++) dat[w*32 +: 32] = $urandom;
      c0Rx[d].rspValid      = 1'b1;
      c0Rx[d].hdr.resp_type = eRSP_RDLINE;
      c0Rx[d].hdr.mdata     = p.mdata;
      c0Rx[d].data          = dat;
      s.cyc = cyc + 1; s.idx = p.mdata; s.data = dat; s.last = (sent.size() == cur_lines - 1);
      sent.push_back(s);
      inflight--;
    end
    if (ack_due == cyc) begin
      c1Rx[d].rspValid      = 1'b1;
      c1Rx[d].hdr.resp_type = eRSP_WRLINE;
      ack_cyc = cyc;
    end
    alm = (cyc >= alm_from) && (cyc < alm_to);
    c0TxAlmFull[d] = alm;
    prev_alm = alm;
  endtask

  task automatic go(input int d);
    hc_control[d] = HC_CTL_IDLE;
    step(d);
    hc_control[d] = HC_CTL_START;
  endtask

  task automatic run_until_done(input int d, input int budget);
    for (int k = 0; k < budget && done_cyc < 0; k++) step(d);
    step(d);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    hc_control[0] = HC_CTL_START;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy[d], done[d], rd_valid[d], c0Tx[d].valid, c1Tx[d].valid} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got=%b want=00000", d,
                 {busy[d], done[d], rd_valid[d], c0Tx[d].valid, c1Tx[d].valid});
      end
    end
    clear_logs(4, 0, 0);
    reset = 1'b0;
    repeat (5) step(0);
    total++;
    if (busy[0] !== 1'b0 || reqs.size() != 0) begin
      bad++;
      $display("FAIL reset_held_start busy=%b reqs=%0d want busy=0 reqs=0", busy[0], reqs.size());
    end
    $display("reset: held start after reset did not launch, reqs=%0d", reqs.size());
    hc_control[0] = HC_CTL_IDLE;
    step(0);
  endtask

  task automatic test_basic;
    hc_buffer[0].address = 42'h1000;
    hc_buffer[0].size    = 32'd4;
    hc_dsm_base          = t_hc_address'({$urandom, $urandom});
    clear_logs(4, 0, int'($urandom_range(0, 3)));
    go(0);
    run_until_done(0, 200);
    total++;
    if (done_cyc < 0 || reqs.size() != 4) begin
      bad++; $display("FAIL basic_reqs done_cyc=%0d reqs=%0d want reqs=4", done_cyc, reqs.size());
    end
    for (int i = 0; i < reqs.size(); i++) begin
      total++;
      if (reqs[i].addr !== t_hc_address'(42'h1000 + i) || reqs[i].mdata !== 16'(i) ||
          reqs[i].attr !== 8'h00 || reqs[i].cyc != reqs[0].cyc + i) begin
        bad++;
        $display("FAIL basic_req%0d addr=%0h mdata=%0d attr=%0h cyc=%0d want addr=%0h mdata=%0d attr=0 cyc=%0d",
                 i, reqs[i].addr, reqs[i].mdata, reqs[i].attr, reqs[i].cyc, 42'h1000 + i, i, reqs[0].cyc + i);
      end
    end
    total++;
    if (got.size() != 4 || sent.size() != 4) begin
      bad++; $display("FAIL basic_nrd got=%0d sent=%0d want 4", got.size(), sent.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      total++;
      if (got[i] != sent[i]) begin
        bad++;
        $display("FAIL basic_rd%0d idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d", i,
                 got[i].idx, got[i].last, got[i].cyc, sent[i].idx, sent[i].last, sent[i].cyc);
      end
    end
    total++;
    if (wr_cnt != 1 || wr_data[63:0] !== 64'h0000_0004_0000_0001 || wr_data[511:64] !== '0 ||
        wr_addr !== hc_dsm_base || wr_sop !== 1'b1 || wr_type !== 4'h0) begin
      bad++;
      $display("FAIL basic_dsm cnt=%0d data=%0h addr=%0h sop=%b want cnt=1 data=0000000400000001 addr=%0h sop=1",
               wr_cnt, wr_data[63:0], wr_addr, wr_sop, hc_dsm_base);
    end
    total++;
    if (ack_cyc < 0 || done_cyc != ack_cyc + 1 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL basic_done done_cyc=%0d busy=%b want done_cyc=%0d busy=0", done_cyc, busy[0], ack_cyc + 1);
    end
    $display("basic: lines=4 reqs=%0d rd=%0d dsm=%0h", reqs.size(), got.size(), wr_data[63:0]);
    hc_control[0] = HC_CTL_IDLE;
    step(0); step(0);
  endtask

  task automatic test_reverse;
    t_hc_address base;
    int          nlast;
    base = t_hc_address'({$urandom_range(0, 255), $urandom}) << 6;
    hc_buffer[0].address = base;
    hc_buffer[0].size    = 32'd8;
    clear_logs(8, 1, 0);
    go(0);
    repeat (3) step(0);
    hc_control[0] = HC_CTL_IDLE;
    step(0);
    hc_control[0] = HC_CTL_START;
    run_until_done(0, 300);
    nlast = 0;
    total++;
    if (got.size() != 8 || reqs.size() != 8 || wr_cnt != 1) begin
      bad++; $display("FAIL rev_counts rd=%0d reqs=%0d wr=%0d want 8 8 1", got.size(), reqs.size(), wr_cnt);
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      if (got[i].last) nlast++;
      total++;
      if (got[i].idx !== 16'(7 - i) || got[i] != sent[i]) begin
        bad++;
        $display("FAIL rev_rd%0d idx=%0d last=%b want idx=%0d last=%b", i, got[i].idx, got[i].last, 7 - i, sent[i].last);
      end
    end
    for (int i = 0; i < reqs.size(); i++) begin
      total++;
      if (reqs[i].addr !== base + t_hc_address'(i)) begin
        bad++; $display("FAIL rev_addr%0d got=%0h want=%0h", i, reqs[i].addr, base + t_hc_address'(i));
      end
    end
    total++;
    if (nlast != 1 || got.size() != 8 || got[7].idx !== 16'd0 || got[7].last !== 1'b1) begin
      bad++; $display("FAIL rev_last nlast=%0d want 1 on idx 0", nlast);
    end
    total++;
    if (done[0] !== 1'b1 || wr_data[63:0] !== 64'h0000_0008_0000_0001) begin
      bad++; $display("FAIL rev_done done=%b dsm=%0h want done=1 dsm=0000000800000001", done[0], wr_data[63:0]);
    end
    $display("reverse: lines=8 rd=%0d lasts=%0d", got.size(), nlast);
    hc_control[0] = HC_CTL_IDLE;
    step(0); step(0);
  endtask

  task automatic test_backpressure;
    t_hc_address base;
    base = t_hc_address'($urandom);
    hc_buffer[1].address = base;
    hc_buffer[1].size    = 32'd6;
    clear_logs(6, 0, 10);
    go(1);
    alm_from = cyc + 12;
    alm_to   = cyc + 17;
    run_until_done(1, 400);
    total++;
    if (max_inflight != 2) begin
      bad++; $display("FAIL bp_inflight got=%0d want=2", max_inflight);
    end
    total++;
    if (alm_viol != 0) begin
      bad++; $display("FAIL bp_almfull issued_while_full=%0d want=0", alm_viol);
    end
    total++;
    if (reqs.size() != 6 || got.size() != 6 || done_cyc < 0) begin
      bad++; $display("FAIL bp_counts reqs=%0d rd=%0d done_cyc=%0d want 6 6", reqs.size(), got.size(), done_cyc);
    end
    for (int i = 0; i < got.size() && i < sent.size() && i < reqs.size(); i++) begin
      total++;
      if (got[i] != sent[i] || reqs[i].addr !== base + t_hc_address'(i)) begin
        bad++; $display("FAIL bp_rd%0d idx=%0d addr=%0h want idx=%0d addr=%0h", i, got[i].idx,
                        reqs[i].addr, sent[i].idx, base + t_hc_address'(i));
      end
    end
    $display("backpressure: max_inflight=%0d viol=%0d rd=%0d", max_inflight, alm_viol, got.size());
    hc_control[1] = HC_CTL_IDLE;
    step(1); step(1);
  endtask

  task automatic test_zero_lines;
    hc_buffer[0].address = 42'h2000;
    hc_buffer[0].size    = 32'h0001_0000;
    clear_logs(0, 0, 0);
    go(0);
    run_until_done(0, 100);
    total++;
    if (reqs.size() != 0 || wr_cnt != 1 || wr_data !== 512'h1 || done_cyc != ack_cyc + 1) begin
      bad++;
      $display("FAIL zero_dsm reqs=%0d wr=%0d data=%0h done_cyc=%0d want 0 1 1 %0d",
               reqs.size(), wr_cnt, wr_data[63:0], done_cyc, ack_cyc + 1);
    end
    repeat (10) step(0);
    total++;
    if (done[0] !== 1'b1 || reqs.size() != 0 || wr_cnt != 1) begin
      bad++; $display("FAIL zero_hold done=%b wr=%0d want done=1 wr=1", done[0], wr_cnt);
    end
    hc_control[0] = HC_CTL_IDLE;
    step(0); step(0);
    total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL zero_idle done=%b busy=%b want 0 0", done[0], busy[0]);
    end
    $display("zero_lines: wr=%0d dsm=%0h", wr_cnt, wr_data[63:0]);
  endtask

  task automatic test_reset_mid;
    pend_t p;
    hc_buffer[0].address = t_hc_address'($urandom);
    hc_buffer[0].size    = 32'd8;
    clear_logs(8, 1, 0);
    go(0);
    for (int k = 0; k < 50 && reqs.size() < 3; k++) step(0);
    reset = 1'b1;
    step(0); step(0);
    reset = 1'b0;
    got.delete();
    for (int i = 0; i < 2 && hold.size() > 0; i++) begin
      p = hold.pop_front(); p.due = cyc; pend.push_back(p);
    end
    repeat (8) step(0);
    total++;
    if (got.size() != 0 || busy[0] !== 1'b0 || u_dut.u_tracker.o_outstanding !== '0 || sent.size() != 2) begin
      bad++;
      $display("FAIL mid_reset rd=%0d busy=%b outstanding=%0d late=%0d want 0 0 0 2",
               got.size(), busy[0], u_dut.u_tracker.o_outstanding, sent.size());
    end
    total++;
    if (reqs.size() != 3) begin
      bad++; $display("FAIL mid_reqs got=%0d want=3", reqs.size());
    end
    $display("reset_mid: issued=%0d before reset, late rd=%0d", reqs.size(), got.size());
    clear_logs(8, 0, int'($urandom_range(0, 5)));
    go(0);
    run_until_done(0, 300);
    total++;
    if (reqs.size() != 8 || got.size() != 8 || done_cyc < 0) begin
      bad++; $display("FAIL mid_rerun reqs=%0d rd=%0d want 8 8", reqs.size(), got.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      total++;
      if (got[i] != sent[i]) begin
        bad++; $display("FAIL mid_rd%0d idx=%0d last=%b want idx=%0d last=%b", i, got[i].idx, got[i].last,
                        sent[i].idx, sent[i].last);
      end
    end
    hc_control[0] = HC_CTL_IDLE;
    step(0); step(0);
  endtask

  task automatic test_wrap;
    t_hc_address exp_addr [3];
    exp_addr[0] = 42'h3FF_FFFF_FFFE;
    exp_addr[1] = 42'h3FF_FFFF_FFFF;
    exp_addr[2] = 42'h0;
    hc_buffer[0].address = 42'h3FF_FFFF_FFFE;
    hc_buffer[0].size    = 32'd3;
    clear_logs(3, 0, 1);
    go(0);
    run_until_done(0, 100);
    total++;
    if (reqs.size() != 3 || got.size() != 3) begin
      bad++; $display("FAIL wrap_counts reqs=%0d rd=%0d want 3 3", reqs.size(), got.size());
    end
    for (int i = 0; i < reqs.size() && i < 3; i++) begin
      total++;
      if (reqs[i].addr !== exp_addr[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%0h want=%0h", i, reqs[i].addr, exp_addr[i]);
      end
    end
    $display("wrap: addrs=%0d", reqs.size());
    hc_control[0] = HC_CTL_IDLE;
    step(0);
  endtask

  initial begin
    reset       = 1'b1;
    hc_dsm_base = '0;
    for (int i = 0; i < HC_BUFFER_SIZE; i++) hc_buffer[i] = '0;
    for (int d = 0; d < 2; d++) begin
      hc_control[d] = HC_CTL_IDLE; c0TxAlmFull[d] = 1'b0; c1TxAlmFull[d] = 1'b0;
      c0Rx[d] = '0; c1Rx[d] = '0;
    end
    test_reset();
    test_basic();
    test_reverse();
    test_backpressure();
    test_zero_lines();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/smith_waterman_rd_engine.md
SMITH_WATERMAN_RD_ENGINE -- requirements
Module: smith_waterman_rd_engine

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 64, max in-flight read requests (2..256).
REQ-002 SHALL have parameter BUF_SEL, default 0, index into hc_buffer of the buffer to stream.
REQ-003 SHALL have: clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have: hc_control  in  t_hc_control (32)  host command word from the CSR stage.
REQ-006 SHALL have: hc_dsm_base  in  t_hc_address  cache-line address of the DSM status line.
REQ-007 SHALL have: hc_buffer  in  t_hc_buffer[HC_BUFFER_SIZE]  line address plus size (64B lines) per buffer.
REQ-008 SHALL have: c0TxAlmFull / c1TxAlmFull  in  1 each  CCI-P request-channel backpressure.
REQ-009 SHALL have: c0Rx  in  t_if_ccip_c0_Rx;  c1Rx  in  t_if_ccip_c1_Rx  read-data and write-ack responses.
REQ-010 SHALL have: c0Tx  out  t_if_ccip_c0_Tx;  c1Tx  out  t_if_ccip_c1_Tx  read and write requests, registered.
REQ-011 SHALL have: rd_valid  out  1;  rd_data  out  512;  rd_idx  out  16;  rd_last  out  1  streamed line, no backpressure.
REQ-012 SHALL have: busy  out  1;  done  out  1  status.

Function
REQ-013 SHALL use states IDLE, REQ, DRAIN, WR_DSM, WAIT_ACK, DONE.
REQ-014 IDLE SHALL go to REQ on the cycle hc_control changes from not-HC_CTL_START to HC_CTL_START; level-held start SHALL not retrigger; start seen outside IDLE SHALL be ignored.
REQ-015 On start SHALL latch base = hc_buffer[BUF_SEL].address and lines = hc_buffer[BUF_SEL].size[15:0]; lines==0 SHALL go straight to WR_DSM.
REQ-016 REQ SHALL issue at most one eREQ_RDLINE_I per cycle, only when c0TxAlmFull==0 and outstanding<MAX_OUTSTANDING; address = base + req_idx modulo 2^width(t_hc_address); mdata = req_idx; vc_sel eVC_VA; cl_len one line.
REQ-017 After issuing request lines-1, SHALL go to DRAIN; no further c0Tx.valid.
REQ-018 outstanding SHALL +1 on issue, -1 on eRSP_RDLINE response, unchanged when both occur in one cycle.
REQ-019 Each c0Rx.rspValid with eRSP_RDLINE SHALL produce rd_valid exactly one cycle later with rd_data = response data, rd_idx = response mdata; arrival order, out-of-order permitted.
REQ-020 rd_last SHALL assert with the rd_valid of the lines-th response received.
REQ-021 c0Rx mmio fields SHALL be ignored; responses arriving in IDLE or DONE SHALL be dropped with no rd_valid.
REQ-022 DRAIN SHALL go to WR_DSM the cycle after the final response.
REQ-023 WR_DSM SHALL issue one eREQ_WRLINE_I to hc_dsm_base when c1TxAlmFull==0, sop=1, data[31:0]=32'h1, data[63:32]=lines, rest 0, then go to WAIT_ACK.
REQ-024 WAIT_ACK SHALL go to DONE on c1Rx.rspValid with eRSP_WRLINE.
REQ-025 DONE SHALL hold done=1 until hc_control==0, then go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE and DONE.
REQ-027 c0Tx.valid and c1Tx.valid SHALL each be single-cycle pulses per request.

Reset
REQ-028 reset SHALL asynchronously force IDLE; all valids, busy, done, counters, latched base/lines to 0.
REQ-029 Reset mid-operation SHALL abandon the transfer; late responses after reset SHALL be dropped per REQ-021.
REQ-030 First start after reset deassertion SHALL need a fresh not-start to start edge on hc_control.

Structure
REQ-031 HC_CTL_START (32'h1), HC_CTL_IDLE (32'h0) and the state enum SHALL live in smith_waterman_pkg.
REQ-032 SHALL instantiate one sub-module, smith_waterman_rd_tracker, holding issue index, response count and outstanding counter.

Verification
REQ-033 base=0x1000, lines=4, no backpressure: reads to 0x1000..0x1003 on 4 consecutive cycles; 4 rd_valid; rd_last on 4th; DSM write data[63:0]=0x0000_0004_0000_0001; done after ack.
REQ-034 lines=8, responses returned in order 7..0: rd_idx follows 7..0, rd_last with rd_idx=0, exactly 8 rd_valid.
REQ-035 MAX_OUTSTANDING=2, lines=6, responses 10-cycle latency: never more than 2 in flight; c0TxAlmFull high 5 cycles mid-stream: no c0Tx.valid while high.
REQ-036 lines=0: no c0Tx request; DSM write data[63:0]=0x1; done after ack; hc_control held at start does not restart; hc_control=0 returns IDLE.
REQ-037 reset asserted in REQ after 3 of 8 issues, 2 late responses after release: no rd_valid, busy=0, outstanding=0; next start edge runs full 8-line transfer.
REQ-038 base=max line address -1, lines=3: addresses wrap to max-1, max, 0.
